// File: rtl/sprite_compositor_pkg.sv
// Shared types and raster constants for the sprite compositor.
// Types are used by sprite_hit_unit and the sprite_compositor top.
package sprite_compositor_pkg;

    localparam int H_VISIBLE_AREA = 224;
    localparam int V_VISIBLE_AREA = 288;

    localparam int POS_W = 9;
    localparam int RGB_W = 12;

    typedef logic [RGB_W-1:0] rgb12_t;
    typedef logic [POS_W-1:0] sprite_pos_t;

    localparam rgb12_t SPRITE_TRANSPARENT = 12'h000;

    function automatic logic is_opaque(input rgb12_t colour);
        return colour != SPRITE_TRANSPARENT;
    endfunction

endpackage

// File: rtl/sprite_compositor_hit_unit.sv
// One sprite channel: frame-latched position/colour/enable plus the stage-1 hit flop.
// Bounds are compared in 10 bits so sprites at the right/bottom edge clip instead of wrapping.
module sprite_hit_unit
    import sprite_compositor_pkg::*;
#(
    parameter int SPRITE_W = 8,
    parameter int SPRITE_H = 8,
    parameter int SX_W     = 8,
    parameter int SY_W     = 9
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             frame_stb_i,
    input  logic [POS_W-1:0] x_i,
    input  logic [POS_W-1:0] y_i,
    input  logic [RGB_W-1:0] rgb_i,
    input  logic             en_i,
    input  logic [SX_W-1:0]  sx_i,
    input  logic [SY_W-1:0]  sy_i,
    output logic             hit_o,
    output logic [RGB_W-1:0] rgb_o
);

    sprite_pos_t posX_q;
    sprite_pos_t posY_q;
    rgb12_t      colour_q;
    logic        enable_q;
    logic        hit_q;
    logic        hit_d;

    logic [9:0]  beamX;
    logic [9:0]  beamY;
    logic [9:0]  rightEdge;
    logic [9:0]  bottomEdge;

    // Shadow values become active only on the frame strobe, so mid-frame moves never tear.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            posX_q   <= '0;
            posY_q   <= '0;
            colour_q <= '0;
            enable_q <= 1'b0;
            hit_q    <= 1'b0;
        end else begin
            if (frame_stb_i) begin
                posX_q   <= x_i;
                posY_q   <= y_i;
                colour_q <= rgb_i;
                enable_q <= en_i;
            end
            hit_q <= hit_d;
        end
    end

    always_comb begin
        beamX      = 10'(sx_i);
        beamY      = 10'(sy_i);
        rightEdge  = {1'b0, posX_q} + 10'(SPRITE_W);
        bottomEdge = {1'b0, posY_q} + 10'(SPRITE_H);
        hit_d      = enable_q
                     && (beamX >= {1'b0, posX_q}) && (beamX < rightEdge)
                     && (beamY >= {1'b0, posY_q}) && (beamY < bottomEdge);
    end

    assign hit_o = hit_q;
    assign rgb_o = colour_q;

endmodule

// File: rtl/sprite_compositor.sv
// N-channel sprite/background mixer: fixed priority (channel 0 highest), 12'h000 transparent, 2-cycle latency.
// Define SPRITE_COMPOSITOR_COLLISION_EN to build the per-frame player collision reporter.
module sprite_compositor
    import sprite_compositor_pkg::*;
#(
    parameter int N_SPRITES    = 5,
    parameter int SPRITE_W     = 8,
    parameter int SPRITE_H     = 8,
    parameter int H_MAP_WIDTH  = H_VISIBLE_AREA,
    parameter int V_MAP_HEIGHT = V_VISIBLE_AREA
) (
    input  logic                            vga_pix_clk,
    input  logic                            rst,
    input  logic                            frame_stb,
    input  logic                            display_enabled,
    input  logic [$clog2(H_MAP_WIDTH)-1:0]  sx,
    input  logic [$clog2(V_MAP_HEIGHT)-1:0] sy,
    input  logic [11:0]                     map_rgb,
    input  logic [N_SPRITES*9-1:0]          spr_x,
    input  logic [N_SPRITES*9-1:0]          spr_y,
    input  logic [N_SPRITES*12-1:0]         spr_rgb,
    input  logic [N_SPRITES-1:0]            spr_en,
    output logic [3:0]                      R,
    output logic [3:0]                      G,
    output logic [3:0]                      B,
    output logic                            collision_stb,
    output logic [N_SPRITES-2:0]            collision_mask
);

    localparam int SX_W = $clog2(H_MAP_WIDTH);
    localparam int SY_W = $clog2(V_MAP_HEIGHT);

    logic [N_SPRITES-1:0] hit;
    rgb12_t               activeRgb [N_SPRITES];
    logic                 displayEn_q;
    rgb12_t               pixel_q;
    rgb12_t               pixel_d;

    for (genvar g = 0; g < N_SPRITES; g++) begin : g_channel
        sprite_hit_unit #(
            .SPRITE_W (SPRITE_W),
            .SPRITE_H (SPRITE_H),
            .SX_W     (SX_W),
            .SY_W     (SY_W)
        ) u_hit (
            .clk_i       (vga_pix_clk),
            .rst_i       (rst),
            .frame_stb_i (frame_stb),
            .x_i         (spr_x[g*POS_W +: POS_W]),
            .y_i         (spr_y[g*POS_W +: POS_W]),
            .rgb_i       (spr_rgb[g*RGB_W +: RGB_W]),
            .en_i        (spr_en[g]),
            .sx_i        (sx),
            .sy_i        (sy),
            .hit_o       (hit[g]),
            .rgb_o       (activeRgb[g])
        );
    end

    // Walk from lowest to highest priority so the lowest opaque hit index overwrites the rest.
    always_comb begin
        pixel_d = map_rgb;
        for (int i = N_SPRITES - 1; i >= 0; i--) begin
            if (hit[i] && is_opaque(activeRgb[i])) begin
                pixel_d = activeRgb[i];
            end
        end
        if (!displayEn_q) begin
            pixel_d = '0;
        end
    end

    always_ff @(posedge vga_pix_clk) begin
        if (rst) begin
            displayEn_q <= 1'b0;
            pixel_q     <= '0;
        end else begin
            displayEn_q <= display_enabled;
            pixel_q     <= pixel_d;
        end
    end

    assign R = pixel_q[11:8];
    assign G = pixel_q[7:4];
    assign B = pixel_q[3:0];

`ifdef SPRITE_COMPOSITOR_COLLISION_EN
    logic [N_SPRITES-2:0] collTerm;
    logic [N_SPRITES-2:0] collMerged;
    logic [N_SPRITES-2:0] collAcc_q;
    logic [N_SPRITES-2:0] collAcc_d;
    logic [N_SPRITES-2:0] collMask_q;
    logic [N_SPRITES-2:0] collMask_d;
    logic                 collStb_q;
    logic                 collStb_d;

    // The strobe cycle's own overlap is folded in, so a hit on the last visible pixel is not lost.
    always_comb begin
        collTerm   = hit[N_SPRITES-1:1] & {(N_SPRITES-1){hit[0] & displayEn_q}};
        collMerged = collAcc_q | collTerm;
        collAcc_d  = collMerged;
        collMask_d = collMask_q;
        collStb_d  = 1'b0;
        if (frame_stb) begin
            collMask_d = collMerged;
            collStb_d  = |collMerged;
            collAcc_d  = '0;
        end
    end

    always_ff @(posedge vga_pix_clk) begin
        if (rst) begin
            collAcc_q  <= '0;
            collMask_q <= '0;
            collStb_q  <= 1'b0;
        end else begin
            collAcc_q  <= collAcc_d;
            collMask_q <= collMask_d;
            collStb_q  <= collStb_d;
        end
    end

    assign collision_stb  = collStb_q;
    assign collision_mask = collMask_q;
`else
    assign collision_stb  = 1'b0;
    assign collision_mask = '0;
`endif

endmodule

// File: tb/tb_sprite_compositor.sv
// Self-checking bench for sprite_compositor: directed scenarios plus randomized pixels vs a geometric model.
// Collision expectations follow SPRITE_COMPOSITOR_COLLISION_EN (all-zero when undefined).
module tb_sprite_compositor;

    localparam int N  = 5;
    localparam int SW = 8;
    localparam int SH = 8;

    typedef struct {
        int x;
        int y;
        bit d;
        bit fs;
        bit r;
    } step_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             frame_stb;
    logic             de;
    logic [7:0]       sx;
    logic [8:0]       sy;
    logic [11:0]      map_rgb;
    logic [N*9-1:0]   spr_x;
    logic [N*9-1:0]   spr_y;
    logic [N*12-1:0]  spr_rgb;
    logic [N-1:0]     spr_en;
    logic [3:0]       R, G, B;
    logic             collision_stb;
    logic [N-2:0]     collision_mask;

    logic [8:0]       shX   [N];
    logic [8:0]       shY   [N];
    logic [11:0]      shRgb [N];
    logic             shEn  [N];

    int               actX   [N];
    int               actY   [N];
    int               actRgb [N];
    bit               actEn  [N];

    int               pipeExp   [2];
    bit               pipeValid [2];
    logic [11:0]      prevMap;
    logic [N-2:0]     accMask;
    logic [N-2:0]     mMask;
    bit               mStb;
    bit               started;

    int               passed;
    int               total;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            spr_x[i*9 +: 9]    = shX[i];
            spr_y[i*9 +: 9]    = shY[i];
            spr_rgb[i*12 +: 12] = shRgb[i];
            spr_en[i]          = shEn[i];
        end
    end

    sprite_compositor dut (
        .vga_pix_clk     (clk),
        .rst             (rst),
        .frame_stb       (frame_stb),
        .display_enabled (de),
        .sx              (sx),
        .sy              (sy),
        .map_rgb         (map_rgb),
        .spr_x           (spr_x),
        .spr_y           (spr_y),
        .spr_rgb         (spr_rgb),
        .spr_en          (spr_en),
        .R               (R),
        .G               (G),
        .B               (B),
        .collision_stb   (collision_stb),
        .collision_mask  (collision_mask)
    );

    function automatic step_t mk(input int x, input int y, input bit d, input bit fs, input bit r);
        step_t s;
        s.x = x; s.y = y; s.d = d; s.fs = fs; s.r = r;
        return s;
    endfunction

    function automatic bit inSprite(input int i, input int x, input int y);
        return actEn[i] && x >= actX[i] && x < actX[i] + SW && y >= actY[i] && y < actY[i] + SH;
    endfunction

    function automatic int expectedColour(input int x, input int y, input bit d, input int m);
        if (!d) return 0;
        for (int i = 0; i < N; i++) begin
            if (inSprite(i, x, y) && actRgb[i] != 0) return actRgb[i];
        end
        return m;
    endfunction

    // One pixel clock: sample outputs, drive the next beam position, advance the reference model.
    task automatic tick(input step_t s, output logic [11:0] gotPix, output int wantPix,
                        output bit collChk, output logic gotStb, output logic [N-2:0] gotMask,
                        output bit wantStb, output logic [N-2:0] wantMask);
        int m;
        @(negedge clk);
        gotPix   = {R, G, B};
        wantPix  = pipeValid[1] ? pipeExp[1] : -1;
        collChk  = started;
        gotStb   = collision_stb;
        gotMask  = collision_mask;
        wantStb  = mStb;
        wantMask = mMask;
        map_rgb  = prevMap;
        m        = int'($urandom_range(0, 4095));
        prevMap  = 12'(m);
        rst       = s.r;
        sx        = 8'(s.x);
        sy        = 9'(s.y);
        de        = s.d;
        frame_stb = s.fs;
        pipeExp[1]   = pipeExp[0];
        pipeValid[1] = pipeValid[0];
        pipeExp[0]   = expectedColour(s.x, s.y, s.d, m);
        pipeValid[0] = started;
        mStb = 1'b0;
        if (s.fs) begin
`ifdef SPRITE_COMPOSITOR_COLLISION_EN
            mMask = accMask;
            mStb  = |accMask;
`endif
            accMask = '0;
        end
        if (s.d) begin
            for (int k = 1; k < N; k++) begin
                if (inSprite(0, s.x, s.y) && inSprite(k, s.x, s.y)) accMask[k-1] = 1'b1;
            end
        end
        if (s.fs) begin
            for (int i = 0; i < N; i++) begin
                actX[i] = int'(shX[i]); actY[i] = int'(shY[i]);
                actRgb[i] = int'(shRgb[i]); actEn[i] = shEn[i];
            end
        end
        if (s.r) begin
            started = 1'b1;
            pipeExp[0] = 0; pipeExp[1] = 0;
            pipeValid[0] = 1'b1; pipeValid[1] = 1'b1;
            accMask = '0; mMask = '0; mStb = 1'b0;
            for (int i = 0; i < N; i++) actEn[i] = 1'b0;
        end
    endtask

    task automatic clearShadow();
        for (int i = 0; i < N; i++) begin
            shX[i] = '0; shY[i] = '0; shRgb[i] = '0; shEn[i] = 1'b0;
        end
    endtask

    task automatic randomiseShadow();
        for (int i = 0; i < N; i++) begin
            shX[i]   = 9'($urandom_range(20, 60));
            shY[i]   = 9'($urandom_range(20, 60));
            shRgb[i] = ($urandom_range(0, 3) == 0) ? 12'h000 : 12'($urandom_range(1, 4095));
            shEn[i]  = ($urandom_range(0, 4) != 0);
        end
    endtask

    task automatic test_reset();
        step_t q[$];
        logic [11:0] gp; int wp; bit cc; logic gs; logic [N-2:0] gm; bit ws; logic [N-2:0] wm;
        q = '{mk(0,0,0,0,1), mk(0,0,0,0,1), mk(0,0,0,0,0), mk(0,0,0,0,0), mk(0,0,0,0,0)};
        foreach (q[j]) begin
            tick(q[j], gp, wp, cc, gs, gm, ws, wm);
            if (wp >= 0) begin
                total++;
                if (gp !== 12'(wp)) $display("[TB] FAIL reset_rgb: got %h want %h", gp, 12'(wp));
                else passed++;
            end
            if (cc) begin
                total++;
                if (gs !== ws || gm !== wm)
                    $display("[TB] FAIL reset_collision: got stb=%b mask=%b want stb=%b mask=%b", gs, gm, ws, wm);
                else passed++;
            end
        end
    endtask

    task automatic test_basic();
        step_t q[$];
        logic [11:0] gp; int wp; bit cc; logic gs; logic [N-2:0] gm; bit ws; logic [N-2:0] wm;
        clearShadow();
        shX[0] = 9'd16; shY[0] = 9'd24; shRgb[0] = 12'hFFF; shEn[0] = 1'b1;
        q = '{mk(0,0,0,1,0), mk(16,24,1,0,0), mk(24,24,1,0,0), mk(23,31,1,0,0),
              mk(15,24,1,0,0), mk(16,32,1,0,0), mk(0,0,0,0,0), mk(0,0,0,0,0)};
        foreach (q[j]) begin
            tick(q[j], gp, wp, cc, gs, gm, ws, wm);
            if (wp >= 0) begin
                total++;
                if (gp !== 12'(wp)) $display("[TB] FAIL basic_rgb step %0d: got %h want %h", j, gp, 12'(wp));
                else passed++;
            end
        end
    endtask

    task automatic test_priority();
        step_t q[$];
        logic [11:0] gp; int wp; bit cc; logic gs; logic [N-2:0] gm; bit ws; logic [N-2:0] wm;
        clearShadow();
        shX[0] = 9'd10; shY[0] = 9'd10; shRgb[0] = 12'hFFF; shEn[0] = 1'b1;
        shX[1] = 9'd12; shY[1] = 9'd12; shRgb[1] = 12'hF00; shEn[1] = 1'b1;
        q = '{mk(0,0,0,1,0), mk(13,13,1,0,0), mk(11,11,1,0,0), mk(19,19,1,0,0), mk(0,0,0,0,0)};
        for (int phase = 0; phase < 2; phase++) begin
            if (phase == 1) shRgb[0] = 12'h000;
            foreach (q[j]) begin
                tick(q[j], gp, wp, cc, gs, gm, ws, wm);
                if (wp >= 0) begin
                    total++;
                    if (gp !== 12'(wp)) $display("[TB] FAIL priority_rgb phase %0d: got %h want %h", phase, gp, 12'(wp));
                    else passed++;
                end
            end
        end
    endtask

    task automatic test_shadow();
        step_t q[$];
        logic [11:0] gp; int wp; bit cc; logic gs; logic [N-2:0] gm; bit ws; logic [N-2:0] wm;
        clearShadow();
        shX[0] = 9'd16; shY[0] = 9'd24; shRgb[0] = 12'h0F0; shEn[0] = 1'b1;
        q = '{mk(0,0,0,1,0), mk(16,24,1,0,0), mk(17,25,1,0,0), mk(40,24,1,0,0),
              mk(16,24,1,0,0), mk(40,24,1,0,0), mk(0,0,0,1,0), mk(16,24,1,0,0),
              mk(40,24,1,0,0), mk(0,0,0,0,0), mk(0,0,0,0,0)};
        foreach (q[j]) begin
            if (j == 2) shX[0] = 9'd40;
            tick(q[j], gp, wp, cc, gs, gm, ws, wm);
            if (wp >= 0) begin
                total++;
                if (gp !== 12'(wp)) $display("[TB] FAIL shadow_rgb step %0d: got %h want %h", j, gp, 12'(wp));
                else passed++;
            end
        end
    endtask

    task automatic test_edge();
        step_t q[$];
        logic [11:0] gp; int wp; bit cc; logic gs; logic [N-2:0] gm; bit ws; logic [N-2:0] wm;
        clearShadow();
        shX[0] = 9'd220; shY[0] = 9'd0; shRgb[0] = 12'h00F; shEn[0] = 1'b1;
        q.push_back(mk(0,0,0,1,0));
        for (int x = 218; x < 224; x++) q.push_back(mk(x, 0, 1, 0, 0));
        for (int x = 0; x < 4; x++) q.push_back(mk(x, 0, 1, 0, 0));
        q.push_back(mk(220, 7, 1, 0, 0));
        q.push_back(mk(220, 8, 1, 0, 0));
        q.push_back(mk(0, 0, 0, 0, 0));
        q.push_back(mk(0, 0, 0, 0, 0));
        foreach (q[j]) begin
            tick(q[j], gp, wp, cc, gs, gm, ws, wm);
            if (wp >= 0) begin
                total++;
                if (gp !== 12'(wp)) $display("[TB] FAIL edge_rgb step %0d: got %h want %h", j, gp, 12'(wp));
                else passed++;
            end
        end
    endtask

    task automatic test_collision();
        step_t q[$];
        logic [11:0] gp; int wp; bit cc; logic gs; logic [N-2:0] gm; bit ws; logic [N-2:0] wm;
        clearShadow();
        shX[0] = 9'd50; shY[0] = 9'd50; shRgb[0] = 12'h0F0; shEn[0] = 1'b1;
        shX[2] = 9'd57; shY[2] = 9'd57; shRgb[2] = 12'h00F; shEn[2] = 1'b1;
        q.push_back(mk(0, 0, 0, 1, 0));
        for (int y = 55; y < 59; y++)
            for (int x = 55; x < 59; x++) q.push_back(mk(x, y, 1, 0, 0));
        q.push_back(mk(0, 0, 0, 1, 0));
        q.push_back(mk(0, 0, 0, 0, 0));
        q.push_back(mk(0, 0, 0, 0, 0));
        for (int phase = 0; phase < 2; phase++) begin
            if (phase == 1) begin
                shX[2] = 9'd100; shY[2] = 9'd100;
            end
            foreach (q[j]) begin
                tick(q[j], gp, wp, cc, gs, gm, ws, wm);
                if (wp >= 0) begin
                    total++;
                    if (gp !== 12'(wp)) $display("[TB] FAIL coll_rgb phase %0d: got %h want %h", phase, gp, 12'(wp));
                    else passed++;
                end
                if (cc) begin
                    total++;
                    if (gs !== ws || gm !== wm)
                        $display("[TB] FAIL collision phase %0d step %0d: got stb=%b mask=%b want stb=%b mask=%b",
                                 phase, j, gs, gm, ws, wm);
                    else passed++;
                end
            end
        end
    endtask

    task automatic test_display();
        step_t q[$];
        logic [11:0] gp; int wp; bit cc; logic gs; logic [N-2:0] gm; bit ws; logic [N-2:0] wm;
        clearShadow();
        shX[0] = 9'd30; shY[0] = 9'd30; shRgb[0] = 12'hABC; shEn[0] = 1'b1;
        q = '{mk(0,0,0,1,0), mk(31,31,0,0,0), mk(31,31,1,0,0), mk(0,0,0,0,1),
              mk(0,0,0,0,0), mk(31,31,1,0,0), mk(30,30,1,0,0), mk(0,0,0,1,0),
              mk(31,31,1,0,0), mk(0,0,0,0,0), mk(0,0,0,0,0)};
        foreach (q[j]) begin
            tick(q[j], gp, wp, cc, gs, gm, ws, wm);
            if (wp >= 0) begin
                total++;
                if (gp !== 12'(wp)) $display("[TB] FAIL display_rgb step %0d: got %h want %h", j, gp, 12'(wp));
                else passed++;
            end
            if (cc) begin
                total++;
                if (gs !== ws || gm !== wm)
                    $display("[TB] FAIL display_collision step %0d: got stb=%b mask=%b want stb=%b mask=%b",
                             j, gs, gm, ws, wm);
                else passed++;
            end
        end
    endtask

    task automatic test_random();
        step_t s;
        int x, y, k;
        logic [11:0] gp; int wp; bit cc; logic gs; logic [N-2:0] gm; bit ws; logic [N-2:0] wm;
        for (int f = 0; f < 5; f++) begin
            if (f < 4) randomiseShadow();
            for (int p = 0; p < 61; p++) begin
                if (p == 0) begin
                    s = mk(0, 0, 0, 1, 0);
                end else begin
                    if (p == 30) randomiseShadow();
                    k = int'($urandom_range(0, N - 1));
                    if ($urandom_range(0, 3) != 0) begin
                        x = actX[k] + int'($urandom_range(0, SW + 1)) - 1;
                        y = actY[k] + int'($urandom_range(0, SH + 1)) - 1;
                    end else begin
                        x = int'($urandom_range(0, 223));
                        y = int'($urandom_range(0, 287));
                    end
                    if (x < 0) x = 0;
                    if (x > 223) x = 223;
                    if (y < 0) y = 0;
                    if (y > 287) y = 287;
                    s = mk(x, y, ($urandom_range(0, 9) != 0), 1'b0, 1'b0);
                end
                if (f == 4 && p > 2) s = mk(0, 0, 0, 0, 0);
                tick(s, gp, wp, cc, gs, gm, ws, wm);
                if (wp >= 0) begin
                    total++;
                    if (gp !== 12'(wp))
                        $display("[TB] FAIL random_rgb frame %0d pix %0d: got %h want %h", f, p, gp, 12'(wp));
                    else passed++;
                end
                if (cc) begin
                    total++;
                    if (gs !== ws || gm !== wm)
                        $display("[TB] FAIL random_collision frame %0d pix %0d: got stb=%b mask=%b want stb=%b mask=%b",
                                 f, p, gs, gm, ws, wm);
                    else passed++;
                end
            end
        end
    endtask

    initial begin
        passed = 0; total = 0;
        started = 1'b0;
        pipeExp[0] = 0; pipeExp[1] = 0;
        pipeValid[0] = 1'b0; pipeValid[1] = 1'b0;
        prevMap = '0; accMask = '0; mMask = '0; mStb = 1'b0;
        for (int i = 0; i < N; i++) begin
            actX[i] = 0; actY[i] = 0; actRgb[i] = 0; actEn[i] = 1'b0;
        end
        rst = 1'b0; frame_stb = 1'b0; de = 1'b0; sx = '0; sy = '0; map_rgb = '0;
        clearShadow();
        test_reset();
        test_basic();
        test_priority();
        test_shadow();
        test_edge();
        test_collision();
        test_display();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL timeout: simulation exceeded its time budget");
        $fatal(1, "[TB] timeout");
    end

endmodule
